exe_unit_arbiter: RTL and testbench

Shares a single `exe_unit` ALU between two requesters using valid/ready handshakes and round-robin arbitration. It registers the winning request's operands and opcode, then drives the ALU from those registers. It captures the ALU result and flags into an output register and returns them to the requester that issued the operation. It sits between the operand-producing front ends and the shared execution unit.

---
 rtl/exe_arb_pkg.sv | 18 +
 rtl/exe_unit.sv | 43 ++++
 rtl/rr_arb2.sv | 22 ++
 rtl/exe_unit_arbiter.sv | 135 +++++++++++++
 tb/tb_exe_unit_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_arb_pkg.sv
// Shared types and constants for the two-requester execution-unit arbiter.
// Flag indices define the bit order of the {NF, PF, BF1, BF0} flag vector.
package exe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    localparam int FLAG_BF0  = 0;
    localparam int FLAG_BF1  = 1;
    localparam int FLAG_PF   = 2;
    localparam int FLAG_NF   = 3;
    localparam int NUM_FLAGS = 4;
    localparam int NUM_REQ   = 2;

endpackage

// File: rtl/exe_unit.sv
// Small combinational ALU: oper[2:0] selects the operation and oper[3] inverts the result.
// BF0 = carry/borrow out, BF1 = zero result, PF = even parity, NF = result MSB.
module exe_unit #(
    parameter int M = 4,
    parameter int N = 4
) (
    input  logic [M-1:0] i_argA,
    input  logic [M-1:0] i_argB,
    input  logic [N-1:0] i_oper,
    output logic [M-1:0] o_result,
    output logic         o_BF0,
    output logic         o_BF1,
    output logic         o_PF,
    output logic         o_NF
);

    logic [M:0] ext_a;
    logic [M:0] ext_b;
    logic [M:0] raw;

    // Bit M of raw carries the carry-out, the borrow or the bit shifted out.
    always_comb begin
        ext_a = {1'b0, i_argA};
        ext_b = {1'b0, i_argB};
        case (i_oper[2:0])
            3'd0:    raw = ext_a + ext_b;
            3'd1:    raw = ext_a - ext_b;
            3'd2:    raw = ext_a & ext_b;
            3'd3:    raw = ext_a | ext_b;
            3'd4:    raw = ext_a ^ ext_b;
            3'd5:    raw = {i_argA, 1'b0};
            3'd6:    raw = {i_argA[0], 1'b0, i_argA[M-1:1]};
            default: raw = ext_a + (M+1)'(1);
        endcase
        o_result = i_oper[3] ? ~raw[M-1:0] : raw[M-1:0];
    end

    assign o_BF0 = raw[M];
    assign o_BF1 = (o_result == '0);
    assign o_PF  = ~^o_result;
    assign o_NF  = o_result[M-1];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] i_req_valid,
    input  logic       i_last_id,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    always_comb begin
        if (i_req_valid == 2'b11) begin
            o_grant_id = ~i_last_id;
        end else begin
            o_grant_id = ~i_req_valid[0];
        end
        if (|i_req_valid) begin
            o_grant = o_grant_id ? 2'b10 : 2'b01;
        end else begin
            o_grant = 2'b00;
        end
    end

endmodule

// File: rtl/exe_unit_arbiter.sv
// Shares one exe_unit between two valid/ready requesters with round-robin arbitration,
// registering operands, then result/flags, and returning the response to the issuer.
module exe_unit_arbiter
    import exe_arb_pkg::*;
#(
    parameter int M     = 4,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic [NUM_REQ-1:0][M-1:0]    i_argA,
    input  logic [NUM_REQ-1:0][M-1:0]    i_argB,
    input  logic [NUM_REQ-1:0][N-1:0]    i_oper,
    output logic [NUM_REQ-1:0]           o_rsp_valid,
    input  logic [NUM_REQ-1:0]           i_rsp_ready,
    output logic [M-1:0]                 o_result,
    output logic [NUM_FLAGS-1:0]         o_flags,
    output logic                         o_busy,
    output logic [CNT_W-1:0]             o_op_count
);

    arb_state_t             state_q, state_d;
    logic                   last_id_q, last_id_d;
    logic                   id_q, id_d;
    logic [M-1:0]           opA_q, opA_d;
    logic [M-1:0]           opB_q, opB_d;
    logic [N-1:0]           oper_q, oper_d;
    logic [M-1:0]           result_q, result_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic [NUM_REQ-1:0]     grant;
    logic                   grant_id;
    logic [M-1:0]           alu_result;
    logic [NUM_FLAGS-1:0]   alu_flags;

    rr_arb2 u_arb (
        .i_req_valid (i_req_valid),
        .i_last_id   (last_id_q),
        .o_grant     (grant),
        .o_grant_id  (grant_id)
    );

    exe_unit #(.M(M), .N(N)) u_exe (
        .i_argA   (opA_q),
        .i_argB   (opB_q),
        .i_oper   (oper_q),
        .o_result (alu_result),
        .o_BF0    (alu_flags[FLAG_BF0]),
        .o_BF1    (alu_flags[FLAG_BF1]),
        .o_PF     (alu_flags[FLAG_PF]),
        .o_NF     (alu_flags[FLAG_NF])
    );

    // Ready is suppressed while reset is held so nothing appears accepted during reset.
    assign o_req_ready = (state_q == IDLE && i_rst_n) ? grant : '0;

    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        id_d        = id_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        oper_d      = oper_q;
        result_d    = result_q;
        flags_d     = flags_q;
        rsp_valid_d = rsp_valid_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    opA_d     = i_argA[grant_id];
                    opB_d     = i_argB[grant_id];
                    oper_d    = i_oper[grant_id];
                    id_d      = grant_id;
                    last_id_d = grant_id;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                result_d    = alu_result;
                flags_d     = alu_flags;
                rsp_valid_d = id_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (i_rsp_ready[id_q]) begin
                    rsp_valid_d = '0;
                    count_d     = count_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            id_q        <= 1'b0;
            opA_q       <= '0;
            opB_q       <= '0;
            oper_q      <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            rsp_valid_q <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            id_q        <= id_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            oper_q      <= oper_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            rsp_valid_q <= rsp_valid_d;
            count_q     <= count_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_result    = result_q;
    assign o_flags     = flags_q;
    assign o_busy      = (state_q != IDLE);
    assign o_op_count  = count_q;

endmodule

// File: tb/tb_exe_unit_arbiter.sv
// Self-checking bench for exe_unit_arbiter: directed scenarios followed by randomized
// transactions, all checked against a transaction-level reference model.
module tb_exe_unit_arbiter;

    localparam int M       = 4;
    localparam int N       = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MOD = 1 << CNT_W;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][M-1:0]      argA;
    logic [1:0][M-1:0]      argB;
    logic [1:0][N-1:0]      oper;
    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [M-1:0]           result;
    logic [3:0]             flags;
    logic                   busy;
    logic [CNT_W-1:0]       op_count;

    int tests = 0;
    int fails = 0;

    // Reference model state: who won last, and how many responses have completed.
    int m_last_id;
    int m_count;

    always #5 clk = ~clk;

    exe_unit_arbiter #(.M(M), .N(N), .CNT_W(CNT_W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_argA      (argA),
        .i_argB      (argB),
        .i_oper      (oper),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_result    (result),
        .o_flags     (flags),
        .o_busy      (busy),
        .o_op_count  (op_count)
    );

    // ALU behaviour with plain integer arithmetic on 4-bit values.
    function automatic void ref_alu(input int a, input int b, input int op,
                                    output int res, output int flg);
        int r, c, ones;
        c = 0;
        case (op % 8)
            0: begin r = a + b; c = (r > 15) ? 1 : 0; r = r % 16; end
            1: begin c = (a < b) ? 1 : 0; r = (a - b + 16) % 16; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin c = (a >= 8) ? 1 : 0; r = (a * 2) % 16; end
            6: begin c = a % 2; r = a / 2; end
            default: begin r = a + 1; c = (r > 15) ? 1 : 0; r = r % 16; end
        endcase
        if (op >= 8) r = 15 - r;
        ones = 0;
        for (int k = 0; k < 4; k++) ones += (r >> k) & 1;
        res = r;
        flg = c + ((r == 0) ? 2 : 0) + (((ones % 2) == 0) ? 4 : 0) + ((r >= 8) ? 8 : 0);
    endfunction

    function automatic logic [1:0] onehot(input int id);
        return (id != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] vld, input logic [1:0] rdy);
        req_valid = vld;
        rsp_ready = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_args(input int r, input int a, input int b, input int op);
        argA[r] = M'(a);
        argB[r] = M'(b);
        oper[r] = N'(op);
    endtask

    // One full transaction starting in IDLE; returns the ready vector seen at grant time.
    task automatic run_txn(input logic [1:0] vld, input int stall, input bit wrong_rdy,
                           output logic [1:0] seen_ready);
        int id, r, f;
        id = (vld == 2'b11) ? (1 - m_last_id) : (vld[0] ? 0 : 1);
        ref_alu(int'(argA[id]), int'(argB[id]), int'(oper[id]), r, f);
        applyStimulus(vld, 2'b00);
        #1;
        seen_ready = req_ready;
        checkOutput("grant_ready", req_ready, onehot(id));
        checkOutput("idle_busy", busy, 0);
        step();
        checkOutput("exec_ready", req_ready, 0);
        checkOutput("exec_rsp_valid", rsp_valid, 0);
        checkOutput("exec_busy", busy, 1);
        step();
        for (int s = 0; s <= stall; s++) begin
            checkOutput("resp_valid", rsp_valid, onehot(id));
            checkOutput("resp_result", result, r);
            checkOutput("resp_flags", flags, f);
            checkOutput("resp_ready", req_ready, 0);
            checkOutput("resp_count", op_count, m_count);
            if (s < stall) begin
                applyStimulus(vld, wrong_rdy ? onehot(1 - id) : 2'b00);
                step();
            end
        end
        applyStimulus(vld, onehot(id) | (wrong_rdy ? onehot(1 - id) : 2'b00));
        step();
        m_count   = (m_count + 1) % CNT_MOD;
        m_last_id = id;
        checkOutput("done_count", op_count, m_count);
        checkOutput("done_rsp_valid", rsp_valid, 0);
        checkOutput("done_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [1:0] rdy_seen;
        rst_n = 1'b0;
        argA = '0;
        argB = '0;
        oper = '0;
        applyStimulus(2'b00, 2'b00);
        m_last_id = 1;
        m_count   = 0;

        // Reset state
        step();
        step();
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_flags", flags, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_count", op_count, 0);
        checkOutput("rst_ready", req_ready, 0);
        #3 rst_n = 1'b1;
        step();

        // Single request from requester 0: ~(3 - 5) = 4'b0001 with borrow
        set_args(0, 3, 5, 4'b1001);
        set_args(1, 7, 2, 0);
        run_txn(2'b01, 0, 1'b0, rdy_seen);
        checkOutput("single_ready", rdy_seen, 2'b01);

        // Backpressure: five stall cycles on requester 1
        set_args(1, 9, 4, 0);
        run_txn(2'b10, 5, 1'b0, rdy_seen);
        checkOutput("bp_ready", rdy_seen, 2'b10);

        // Wrong-owner ready while requester 1 owns the response
        set_args(1, 12, 6, 4'b0100);
        run_txn(2'b10, 3, 1'b1, rdy_seen);

        // Held tie: grants alternate 0,1,0,1
        set_args(0, 5, 5, 1);
        set_args(1, 15, 1, 0);
        run_txn(2'b11, 0, 1'b0, rdy_seen);
        checkOutput("tie_a", rdy_seen, 2'b01);
        run_txn(2'b11, 0, 1'b0, rdy_seen);
        checkOutput("tie_b", rdy_seen, 2'b10);
        run_txn(2'b11, 1, 1'b0, rdy_seen);
        checkOutput("tie_c", rdy_seen, 2'b01);
        run_txn(2'b11, 0, 1'b1, rdy_seen);
        checkOutput("tie_d", rdy_seen, 2'b10);

        // Reset asserted between edges while an operation is in EXEC
        set_args(0, 8, 8, 0);
        applyStimulus(2'b01, 2'b00);
        step();
        checkOutput("pre_rst_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_ready", req_ready, 0);
        checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
        checkOutput("mid_rst_result", result, 0);
        checkOutput("mid_rst_flags", flags, 0);
        checkOutput("mid_rst_count", op_count, 0);
        applyStimulus(2'b00, 2'b11);
        step();
        step();
        #3 rst_n = 1'b1;
        m_last_id = 1;
        m_count   = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            checkOutput("post_rst_rsp_valid", rsp_valid, 0);
            checkOutput("post_rst_busy", busy, 0);
        end
        applyStimulus(2'b00, 2'b00);

        // Tie from reset, then counter wrap over five completions: 1,2,3,0,1
        set_args(0, 2, 3, 0);
        set_args(1, 4, 4, 1);
        run_txn(2'b11, 0, 1'b0, rdy_seen);
        checkOutput("rst_tie_first", rdy_seen, 2'b01);
        checkOutput("wrap_1", op_count, 1);
        run_txn(2'b11, 0, 1'b0, rdy_seen);
        checkOutput("rst_tie_second", rdy_seen, 2'b10);
        checkOutput("wrap_2", op_count, 2);
        run_txn(2'b01, 0, 1'b0, rdy_seen);
        checkOutput("wrap_3", op_count, 3);
        run_txn(2'b10, 0, 1'b0, rdy_seen);
        checkOutput("wrap_0", op_count, 0);
        run_txn(2'b01, 0, 1'b0, rdy_seen);
        checkOutput("wrap_1b", op_count, 1);

        // Randomized traffic with idle gaps, stalls and wrong-owner ready
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(2'b00, 2'($urandom_range(0, 3)));
                #1;
                checkOutput("rand_idle_ready", req_ready, 0);
                checkOutput("rand_idle_busy", busy, 0);
                checkOutput("rand_idle_rsp_valid", rsp_valid, 0);
                step();
            end else begin
                set_args(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)));
                set_args(1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)));
                run_txn(2'($urandom_range(1, 3)), int'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), rdy_seen);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
